// File: rtl/cds_readout_sequencer.sv
// Row/frame timing sequencer for a correlated-double-sampling readout chain.
// Optional build macro CDS_SEQ_ABORT_EN adds an abort input that drops any running frame.
module cds_readout_sequencer #(
    parameter int CNT_W      = 16,
    parameter int ROW_W      = 10,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] reset_width,
    input  logic [ROW_W-1:0] rows_per_frame,
    input  logic [CNT_W-1:0] delay1_in,
    input  logic [CNT_W-1:0] delay2_in,
`ifdef CDS_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             trigger,
    output logic [CNT_W-1:0] cds_delay1,
    output logic [CNT_W-1:0] cds_delay2,
    output logic [ROW_W-1:0] row_addr,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy,
    output logic             cfg_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ROW  = 2'd2,
        FEND = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] p_r;
    logic [CNT_W-1:0] w_r;
    logic [ROW_W-1:0] r_r;
    logic             cfg_valid_s;
    logic             abort_s;

`ifdef CDS_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Legality of the live configuration inputs, evaluated only when leaving IDLE.
    always_comb begin
        cfg_valid_s = 1'b0;
        if ((period >= CNT_W'(MIN_PERIOD)) &&
            (reset_width != {CNT_W{1'b0}}) && (reset_width < period) &&
            (rows_per_frame != {ROW_W{1'b0}}) &&
            (delay1_in < delay2_in) && (delay2_in < period)) begin
            cfg_valid_s = 1'b1;
        end else begin
            cfg_valid_s = 1'b0;
        end
    end

    // Sequencer FSM; every output describes the state occupied during the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            p_r         <= {CNT_W{1'b0}};
            w_r         <= {CNT_W{1'b0}};
            r_r         <= {ROW_W{1'b0}};
            row_addr    <= {ROW_W{1'b0}};
            trigger     <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            cfg_error   <= 1'b0;
            cds_delay1  <= {CNT_W{1'b0}};
            cds_delay2  <= {CNT_W{1'b0}};
        end else if (abort_s && (state_r != IDLE)) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            row_addr    <= {ROW_W{1'b0}};
            trigger     <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            trigger     <= 1'b0;
            busy        <= (state_r != IDLE);
            if (!enable) begin
                cfg_error <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    cnt_r    <= {CNT_W{1'b0}};
                    row_addr <= {ROW_W{1'b0}};
                    if (enable && cfg_valid_s) begin
                        state_r <= ARM;
                    end else if (enable) begin
                        cfg_error <= 1'b1;
                    end
                end
                ARM: begin
                    p_r         <= period;
                    w_r         <= reset_width;
                    r_r         <= rows_per_frame;
                    cds_delay1  <= delay1_in;
                    cds_delay2  <= delay2_in;
                    row_addr    <= {ROW_W{1'b0}};
                    cnt_r       <= {CNT_W{1'b0}};
                    frame_start <= 1'b1;
                    state_r     <= ROW;
                end
                ROW: begin
                    trigger <= (cnt_r < w_r);
                    // Terminal compare at P-1 keeps the counter strictly below P.
                    if (cnt_r == (p_r - CNT_W'(1))) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (row_addr == (r_r - ROW_W'(1))) begin
                            state_r <= FEND;
                        end else begin
                            row_addr <= row_addr + ROW_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                FEND: begin
                    frame_done <= 1'b1;
                    if (enable) begin
                        state_r <= ARM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
